// File: rtl/adder_share_sched.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder among NREQ requesters
// and holds the tagged result in a one-entry output register until the consumer accepts it.
module adder_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  input  logic                  rsp_ready,
  output logic [15:0]           grant_cnt
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [15:0]      r_cnt;

  logic                w_slot_free;
  logic                w_xfer;
  logic                w_found;
  logic [2*NREQ-1:0]   w_dbl;
  logic [NREQ-1:0]     w_rot;
  logic [NREQ-1:0]     w_grant;
  logic [IDW:0]        w_off;
  logic [IDW:0]        w_idx;
  logic [IDW:0]        w_nxt;
  logic [IDW-1:0]      w_gid;
  logic [IDW-1:0]      w_ptr_nxt;
  logic [WIDTH-1:0]    w_a;
  logic [WIDTH-1:0]    w_b;
  logic [WIDTH:0]      w_add;

  assign w_slot_free = (r_state == EMPTY) || rsp_ready;

  // Rotate the request vector so the pointer position lands at bit 0; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign w_dbl = {req_valid, req_valid} >> r_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = (IDW+1)'(k);
      end
    end
  end

  always_comb begin
    w_idx = {1'b0, r_ptr} + w_off;
    if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
  end

  assign w_gid     = w_idx[IDW-1:0];
  assign w_xfer    = rst_n && w_slot_free && w_found;
  assign w_grant   = w_xfer ? (NREQ'(1) << w_gid) : '0;
  assign req_ready = w_grant;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gid == IDW'(i)) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_add = {1'b0, w_a} + {1'b0, w_b};

  always_comb begin
    w_nxt = {1'b0, w_gid} + (IDW+1)'(1);
    if (w_nxt == NREQ_W) w_nxt = '0;
  end

  assign w_ptr_nxt = w_nxt[IDW-1:0];

  // Output register occupancy: a transfer always fills, a drain alone empties.
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer)         w_state_nxt = FULL;
    else if (rsp_ready) w_state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_gid;
      r_sum   <= w_add[WIDTH-1:0];
      r_carry <= w_add[WIDTH];
      r_cnt   <= r_cnt + 16'd1;
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_carry = r_carry;
  assign grant_cnt = r_cnt;

endmodule
